// File: rtl/seq_array_divider.sv
// -----------------------------------------------------------------------------
// seq_array_divider
//
// Iterative restoring unsigned divider: the inverse of the tile's 4x4 array
// multiplier. It divides a product-width dividend by a narrow divisor and
// produces one quotient bit per clock, MSB first. There are valid/ready
// handshakes on the operand side and on the result side. Only one operation
// is in flight at a time.
//
// Ports
//   clk          in   1           single clock; all state updates on rising edge
//   rst          in   1           synchronous, active-high reset
//   in_valid     in   1           dividend/divisor present
//   in_ready     out  1           block can accept an operand pair (registered)
//   dividend     in   DIVIDEND_W  unsigned dividend
//   divisor      in   DIVISOR_W   unsigned divisor
//   out_valid    out  1           result registers hold a valid result (registered)
//   out_ready    in   1           consumer takes the result
//   quotient     out  DIVIDEND_W  unsigned quotient (all ones on divide-by-zero)
//   remainder    out  DIVISOR_W   unsigned remainder, < divisor when divisor != 0
//   div_by_zero  out  1           result was produced with divisor == 0
//
// Timing
//   A normal division asserts out_valid DIVIDEND_W cycles after the accept edge.
//   A divide-by-zero asserts out_valid one cycle after the accept edge.
// -----------------------------------------------------------------------------
module seq_array_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  // The partial remainder is one bit wider than the divisor so that the
  // shifted-in value can reach 2*divisor-1 before the trial subtract.
  localparam int REM_W = DIVISOR_W + 1;
  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;

  // A single shift register serves both the dividend and the quotient. Each
  // step shifts the next dividend MSB out of the top and the new quotient bit
  // in at the bottom. After DIVIDEND_W steps it holds the whole quotient.
  logic [DIVIDEND_W-1:0] work_sr;
  logic [DIVISOR_W-1:0]  divisor_q;
  logic [REM_W-1:0]      part_rem;
  logic [CNT_W-1:0]      count;

  // One restoring step, computed combinationally from the current state.
  logic [REM_W:0]        rem_shift;
  logic [REM_W:0]        divisor_ext;
  logic                  q_bit;
  logic [REM_W-1:0]      rem_next;
  logic [DIVIDEND_W-1:0] work_next;

  // NOTE: every signal driven here gets a default before any conditional
  // logic. Without the defaults, a path that skips an assignment infers a latch.
  always_comb begin
    rem_shift   = {part_rem, work_sr[DIVIDEND_W-1]};
    divisor_ext = {2'b00, divisor_q};
    q_bit       = (rem_shift >= divisor_ext);
    rem_next    = rem_shift[REM_W-1:0];
    if (q_bit) begin
      // The difference is always < divisor, so truncating to REM_W bits
      // loses nothing.
      rem_next = REM_W'(rem_shift - divisor_ext);
    end
    work_next = {work_sr[DIVIDEND_W-2:0], q_bit};
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together from pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // rst aborts any operation in flight and has priority over both
      // handshakes.
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      work_sr     <= '0;
      divisor_q   <= '0;
      part_rem    <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            // Sample the operands only here. Later changes on the inputs
            // cannot reach the result.
            work_sr   <= dividend;
            divisor_q <= divisor;
            part_rem  <= '0;
            count     <= '0;
            in_ready  <= 1'b0;
            if (divisor == '0) begin
              // Write the result now and skip the iteration. out_valid
              // follows on the first DONE cycle.
              state       <= DONE;
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              state       <= RUN;
              div_by_zero <= 1'b0;
            end
          end
        end

        RUN: begin
          work_sr  <= work_next;
          part_rem <= rem_next;
          count    <= count + 1'b1;
          if (count == LAST_STEP) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= work_next;
            remainder <= rem_next[DIVISOR_W-1:0];
          end
        end

        DONE: begin
          if (!out_valid) begin
            // Entered straight from IDLE on divide-by-zero.
            out_valid <= 1'b1;
          end else if (out_ready) begin
            // The result registers keep their values. Only the
            // handshake flags change.
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_array_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_array_divider
//
// Directed self-checking bench for seq_array_divider. It covers reset values,
// hand-computed quotients and remainders, latency, divide-by-zero and
// backpressure. It also covers abort by reset mid-run and a back-to-back sweep
// of every 8-bit/4-bit operand pair against an arithmetic reference.
// -----------------------------------------------------------------------------
module tb_seq_array_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int tests = 0;
  int fails = 0;

  seq_array_divider #(
    .DIVIDEND_W (8),
    .DIVISOR_W  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one operand pair for a single cycle. Then wait (bounded) for
  // out_valid and check the latency and the result. The task returns sampled
  // #1 after the edge on which out_valid was first seen high.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [3:0] d,
                       input int exp_lat, input logic [7:0] eq,
                       input logic [3:0] er, input logic edz);
    int cyc;
    @(negedge clk);
    dividend = a;
    divisor  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = ~d;
    check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!out_valid && cyc < 20);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_quotient"}, 32'(quotient), 32'(eq));
    check({tag, "_remainder"}, 32'(remainder), 32'(er));
    check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(edz));
  endtask

  // With out_ready high, the handshake happens on the next edge.
  task automatic finish_handshake(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_div_by_zero", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    // out_ready high while idle has no effect
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("idle_out_ready", 32'({out_valid, in_ready}), 32'b01);
    end

    // Basic divisions. 7*28+4 = 200, 1*255 = 255, 15*0+5 = 5.
    do_op("d200_7", 8'd200, 4'd7, 8, 8'd28, 4'd4, 1'b0);
    finish_handshake("d200_7");
    do_op("d255_1", 8'd255, 4'd1, 8, 8'd255, 4'd0, 1'b0);
    finish_handshake("d255_1");
    do_op("d5_15", 8'd5, 4'd15, 8, 8'd0, 4'd5, 1'b0);
    finish_handshake("d5_15");
    do_op("d0_9", 8'd0, 4'd9, 8, 8'd0, 4'd0, 1'b0);
    finish_handshake("d0_9");

    // Divide by zero, with the result available one cycle after accept
    do_op("d42_0", 8'd42, 4'd0, 1, 8'hFF, 4'd0, 1'b1);
    finish_handshake("d42_0");

    // Backpressure test: 100 = 9*11 + 1
    out_ready = 1'b0;
    do_op("bp", 8'd100, 4'd9, 8, 8'd11, 4'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~i[0];
      dividend = 8'd77;
      divisor  = 4'd2;
      @(posedge clk);
      #1;
      check("bp_stable",
            32'({out_valid, in_ready, quotient, remainder, div_by_zero}),
            32'({1'b1, 1'b0, 8'd11, 4'd1, 1'b0}));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    finish_handshake("bp");
    check("bp_hold_quotient", 32'({quotient, remainder}), 32'({8'd11, 4'd1}));

    // Reset asserted at RUN step 4 of 200/7
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 4'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_state",
          32'({out_valid, in_ready, quotient, remainder, div_by_zero}),
          32'({1'b0, 1'b1, 8'd0, 4'd0, 1'b0}));
    do_op("d100_3", 8'd100, 4'd3, 8, 8'd33, 4'd1, 1'b0);
    finish_handshake("d100_3");

    // Back-to-back sweep of all operand pairs with in_valid held high
    @(negedge clk);
    in_valid = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int d = 0; d < 16; d++) begin
        logic [7:0] eq;
        logic [3:0] er;
        logic       edz;
        int         g;
        int         cyc;
        @(negedge clk);
        g = 0;
        while (!in_ready && g < 20) begin
          @(negedge clk);
          g++;
        end
        dividend = a[7:0];
        divisor  = d[3:0];
        @(posedge clk);
        #1;
        // Change the operands during the run. The result must not move.
        dividend = ~a[7:0];
        divisor  = ~d[3:0];
        cyc = 0;
        while (!out_valid && cyc < 20) begin
          @(posedge clk);
          #1;
          cyc++;
        end
        if (d == 0) begin
          eq  = 8'hFF;
          er  = 4'd0;
          edz = 1'b1;
        end else begin
          eq  = 8'(a / d);
          er  = 4'(a % d);
          edz = 1'b0;
        end
        check($sformatf("sweep_%0d_%0d", a, d),
              32'({out_valid, quotient, remainder, div_by_zero}),
              32'({1'b1, eq, er, edz}));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    finish_handshake("sweep_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
